flush_ctrl: RTL

FLUSH_CTRL -- requirements
Module: flush_ctrl

---
 rtl/flush_ctrl_pkg.sv | 28 ++
 rtl/flush_ctrl_if.sv | 28 ++
 rtl/flush_ctrl_decode.sv | 37 +++
 rtl/flush_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/flush_ctrl_pkg.sv
// flush_pkg: shared definitions for the pipeline flush controller.
//   - RV32 major-opcode constants (inst[6:2]) for JAL, JALR and conditional branch
//   - FSM state encoding for flush_ctrl
//   - redirect source encoding driven on redirect_src_o
//   - opcodeOf(): extracts the 5-bit major opcode field from an instruction
package flush_pkg;

   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_BRANCH = 5'b11000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_FLUSH = 2'd2
   } flushState_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_D    = 2'd1,
      SRC_X    = 2'd2
   } redirSrc_t;

   function automatic logic [4:0] opcodeOf(input logic [31:0] inst);
      return inst[6:2];
   endfunction

endpackage

// File: rtl/flush_ctrl_if.sv
// flush_ctrl_if: pipeline <-> flush controller signal bundle.
//   master : pipeline side, drives stall/fetch/instruction/mispredict, observes kill flags
//   slave  : flush_ctrl side
//   stall_i, fetch_valid_i, inst_d_i[31:0], inst_x_i[31:0], predict_fail_i  (to controller)
//   kill_o[NUM_STAGES-1:0], kill_en_o, redirect_src_o[1:0], flush_busy_o   (from controller)
interface flush_ctrl_if #(
   parameter int NUM_STAGES = 5
);
   logic                  stall_i;
   logic                  fetch_valid_i;
   logic [31:0]           inst_d_i;
   logic [31:0]           inst_x_i;
   logic                  predict_fail_i;
   logic [NUM_STAGES-1:0] kill_o;
   logic                  kill_en_o;
   logic [1:0]            redirect_src_o;
   logic                  flush_busy_o;

   modport master (
      output stall_i, fetch_valid_i, inst_d_i, inst_x_i, predict_fail_i,
      input  kill_o, kill_en_o, redirect_src_o, flush_busy_o
   );

   modport slave (
      input  stall_i, fetch_valid_i, inst_d_i, inst_x_i, predict_fail_i,
      output kill_o, kill_en_o, redirect_src_o, flush_busy_o
   );
endinterface

// File: rtl/flush_ctrl_decode.sv
// flush_decode: combinational flush qualification.
//   killD, killX  : current bubble flags of the D and X stages
//   instD, instX  : instructions sitting in D and X
//   predictFail   : branch in X mispredicted
//   xFlush        : JALR in X, or mispredicted conditional branch in X
//   dFlush        : JAL in D with no concurrent X flush (X has priority)
// Macro JAL_EARLY_KILL_EN enables the early JAL kill from D; without it
// dFlush is tied low and JAL is an ordinary instruction.
module flush_decode
   import flush_pkg::*;
(
   input  logic        killD,
   input  logic        killX,
   input  logic [31:0] instD,
   input  logic [31:0] instX,
   input  logic        predictFail,
   output logic        xFlush,
   output logic        dFlush
);

   logic [4:0] opX;
   logic       unusedBits;

   assign opX    = opcodeOf(instX);
   assign xFlush = !killX && (((opX == OP_BRANCH) && predictFail) || (opX == OP_JALR));

`ifdef JAL_EARLY_KILL_EN
   logic [4:0] opD;
   assign opD        = opcodeOf(instD);
   assign dFlush     = !killD && (opD == OP_JAL) && !xFlush;
   assign unusedBits = ^{instD[31:7], instD[1:0], instX[31:7], instX[1:0]};
`else
   assign dFlush     = 1'b0;
   assign unusedBits = ^{killD, instD, instX[31:7], instX[1:0]};
`endif

endmodule

// File: rtl/flush_ctrl.sv
// flush_ctrl: per-stage bubble tracking and flush sequencing.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : flush_ctrl_if.slave (see interface for signal list)
// kill_o is a shift register of bubble flags, stage 0 = F. A flush that
// arrives during a stall is parked in PEND and applied on the first
// non-stall edge, even if the resolving inputs have changed by then.
// Optional feature: define JAL_EARLY_KILL_EN to enable early JAL kill in D.
module flush_ctrl
   import flush_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int X_IDX      = 2,
   parameter int D_IDX      = 1
) (
   input logic         clk,
   input logic         rst_n,
   flush_ctrl_if.slave bus
);

   flushState_t           state, stateNext;
   redirSrc_t             capSrc, capSrcNext;
   redirSrc_t             redirQ, redirNext;
   redirSrc_t             curSrc, applySrc;
   logic [NUM_STAGES-1:0] killQ, killNext;
   logic                  killEnQ;
   logic                  apply;
   logic                  xFlush, dFlush;

   flush_decode uDecode (
      .killD       (killQ[D_IDX]),
      .killX       (killQ[X_IDX]),
      .instD       (bus.inst_d_i),
      .instX       (bus.inst_x_i),
      .predictFail (bus.predict_fail_i),
      .xFlush      (xFlush),
      .dFlush      (dFlush)
   );

   assign curSrc = xFlush ? SRC_X : (dFlush ? SRC_D : SRC_NONE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= stateNext;
   end

   // next state and flush application
   always_comb begin
      stateNext  = state;
      capSrcNext = capSrc;
      apply      = 1'b0;
      applySrc   = SRC_NONE;
      unique case (state)
         ST_IDLE: begin
            if (curSrc != SRC_NONE) begin
               if (bus.stall_i) begin
                  stateNext  = ST_PEND;
                  capSrcNext = curSrc;
               end else begin
                  stateNext = ST_FLUSH;
                  apply     = 1'b1;
                  applySrc  = curSrc;
               end
            end
         end
         ST_PEND: begin
            if (!bus.stall_i) begin
               stateNext  = ST_FLUSH;
               apply      = 1'b1;
               applySrc   = capSrc;
               capSrcNext = SRC_NONE;
            end
         end
         ST_FLUSH: stateNext = ST_IDLE;  // bubbles just inserted make a new flush impossible
         default:  stateNext = ST_IDLE;
      endcase
   end

   // bubble shift register next value
   always_comb begin
      killNext = killQ;
      if (!bus.stall_i) begin
         killNext[0] = !bus.fetch_valid_i;
         for (int i = 1; i < NUM_STAGES; i++) killNext[i] = killQ[i-1];
         if (apply && (applySrc == SRC_X)) begin
            for (int i = 1; i <= X_IDX; i++) killNext[i] = 1'b1;
            killNext[X_IDX+1] = 1'b0;  // resolving instruction itself retires
         end else if (apply && (applySrc == SRC_D)) begin
            for (int i = 1; i <= D_IDX; i++) killNext[i] = 1'b1;
         end
      end
   end

   assign redirNext = apply ? applySrc : redirQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         killQ   <= '1;
         killEnQ <= 1'b0;
         redirQ  <= SRC_NONE;
         capSrc  <= SRC_NONE;
      end else begin
         killQ   <= killNext;
         killEnQ <= apply;
         redirQ  <= redirNext;
         capSrc  <= capSrcNext;
      end
   end

   assign bus.kill_o         = killQ;
   assign bus.kill_en_o      = killEnQ;
   assign bus.redirect_src_o = redirQ;
   assign bus.flush_busy_o   = (state == ST_PEND);

endmodule
